// File: rtl/mnist_infer_sched.sv
// Job scheduler for the sequential MNIST engine: queues image-index requests,
// runs them one at a time with a start/done handshake, timeout abort and a result record.
module mnist_infer_sched #(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned CYC_W   = 20,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [IDX_W-1:0]         req_idx,
    output logic                     req_ready,
    output logic                     acc_start,
    output logic [IDX_W-1:0]         acc_img_sel,
    output logic                     acc_rst,
    input  logic                     acc_done,
    input  logic [3:0]               acc_digit,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDX_W-1:0]         res_idx,
    output logic [3:0]               res_digit,
    output logic [CYC_W-1:0]         res_cycles,
    output logic                     res_timeout,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [2:0]               sched_state
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_TMO   = 3'd3,
        S_POST  = 3'd4
    } state_t;

    // Request FIFO storage and pointers
    logic [IDX_W-1:0] mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head;

    state_t           state;
    state_t           state_nxt;
    logic             acc_start_nxt;
    logic             acc_rst_nxt;
    logic [IDX_W-1:0] img_sel_nxt;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_nxt;
    logic [3:0]       dig;
    logic [3:0]       dig_nxt;
    logic             tmo;
    logic             tmo_nxt;
    logic             res_valid_nxt;
    logic [IDX_W-1:0] res_idx_nxt;
    logic [3:0]       res_digit_nxt;
    logic [CYC_W-1:0] res_cycles_nxt;
    logic             res_timeout_nxt;

    assign q_count     = count;
    assign req_ready   = (count < CNT_W'(QDEPTH));
    assign push        = req_valid && req_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign head        = mem[rd_ptr];
    assign sched_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_idx;
        end
    end

    // Pointers wrap naturally since QDEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc_start   <= 1'b0;
            acc_rst     <= 1'b0;
            acc_img_sel <= '0;
            cyc         <= '0;
            dig         <= '0;
            tmo         <= 1'b0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_digit   <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc_start   <= acc_start_nxt;
            acc_rst     <= acc_rst_nxt;
            acc_img_sel <= img_sel_nxt;
            cyc         <= cyc_nxt;
            dig         <= dig_nxt;
            tmo         <= tmo_nxt;
            res_valid   <= res_valid_nxt;
            res_idx     <= res_idx_nxt;
            res_digit   <= res_digit_nxt;
            res_cycles  <= res_cycles_nxt;
            res_timeout <= res_timeout_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        acc_start_nxt   = acc_start;
        acc_rst_nxt     = 1'b0;
        img_sel_nxt     = acc_img_sel;
        cyc_nxt         = cyc;
        dig_nxt         = dig;
        tmo_nxt         = tmo;
        res_valid_nxt   = res_valid && !res_ready;
        res_idx_nxt     = res_idx;
        res_digit_nxt   = res_digit;
        res_cycles_nxt  = res_cycles;
        res_timeout_nxt = res_timeout;

        case (state)
            S_IDLE: begin
                acc_start_nxt = 1'b0;
                if (pop) begin
                    img_sel_nxt   = head;
                    acc_start_nxt = 1'b1;
                    cyc_nxt       = '0;
                    state_nxt     = S_RUN;
                end
            end
            S_RUN: begin
                acc_start_nxt = 1'b1;
                if (acc_done) begin
                    dig_nxt       = acc_digit;
                    tmo_nxt       = 1'b0;
                    acc_start_nxt = 1'b0;
                    state_nxt     = S_DRAIN;
                end else if (cyc == CYC_W'(TIMEOUT - 1)) begin
                    acc_start_nxt = 1'b0;
                    acc_rst_nxt   = 1'b1;
                    state_nxt     = S_TMO;
                end else begin
                    cyc_nxt = cyc + CYC_W'(1);
                end
            end
            S_DRAIN: begin
                acc_start_nxt = 1'b0;
                if (!acc_done) begin
                    state_nxt = S_POST;
                end
            end
            // One cycle here plus the RUN exit edge keeps acc_rst high for two cycles
            S_TMO: begin
                acc_start_nxt = 1'b0;
                acc_rst_nxt   = 1'b1;
                dig_nxt       = 4'hF;
                tmo_nxt       = 1'b1;
                state_nxt     = S_POST;
            end
            S_POST: begin
                acc_start_nxt = 1'b0;
                if (!res_valid || res_ready) begin
                    res_valid_nxt   = 1'b1;
                    res_idx_nxt     = acc_img_sel;
                    res_digit_nxt   = dig;
                    res_cycles_nxt  = cyc;
                    res_timeout_nxt = tmo;
                    state_nxt       = S_IDLE;
                end
            end
            default: begin
                acc_start_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mnist_infer_sched.sv
// Scoreboard bench for mnist_infer_sched with a behavioural engine whose
// latency/digit are fixed per image index.
module tb_mnist_infer_sched;

    typedef struct packed {
        logic [3:0]  idx;
        logic [3:0]  dig;
        logic [19:0] cyc;
        logic        tmo;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_idx;
    logic        req_ready;
    logic        acc_start;
    logic [3:0]  acc_img_sel;
    logic        acc_rst;
    logic        acc_done;
    logic [3:0]  acc_digit;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_idx;
    logic [3:0]  res_digit;
    logic [19:0] res_cycles;
    logic        res_timeout;
    logic [2:0]  q_count;
    logic [2:0]  sched_state;

    int   checks = 0;
    int   errors = 0;
    int   rec_cnt = 0;
    int   rst_hi_cnt = 0;
    rec_t exp_q[$];

    mnist_infer_sched #(
        .QDEPTH(4), .IDX_W(4), .CYC_W(20), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .acc_start(acc_start), .acc_img_sel(acc_img_sel), .acc_rst(acc_rst),
        .acc_done(acc_done), .acc_digit(acc_digit),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_digit(res_digit), .res_cycles(res_cycles), .res_timeout(res_timeout),
        .q_count(q_count), .sched_state(sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine behaviour per image: done rises so that it is sampled after lat_of() counted RUN edges
    function automatic int lat_of(input logic [3:0] i);
        case (i)
            4'd3:    return 9;
            4'd13:   return 14;
            default: return int'(i & 4'd3) + 1;
        endcase
    endfunction

    function automatic logic [3:0] dig_of(input logic [3:0] i);
        case (i)
            4'd3:    return 4'd7;
            4'd13:   return 4'd2;
            default: return 4'(i % 4'd10);
        endcase
    endfunction

    function automatic bit hang_of(input logic [3:0] i);
        return i == 4'd12;
    endfunction

    function automatic rec_t exp_of(input logic [3:0] i);
        rec_t r;
        r.idx = i;
        if (hang_of(i)) begin
            r.dig = 4'hF;
            r.cyc = 20'd15;
            r.tmo = 1'b1;
        end else begin
            r.dig = dig_of(i);
            r.cyc = 20'(lat_of(i));
            r.tmo = 1'b0;
        end
        return r;
    endfunction

    int eng_cnt = 0;
    logic eng_done = 1'b0;
    assign acc_done  = eng_done;
    assign acc_digit = dig_of(acc_img_sel);

    always @(posedge clk) begin
        if (acc_rst || !acc_start) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
        end else if (!eng_done && !hang_of(acc_img_sel)) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt + 1 == lat_of(acc_img_sel)) eng_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks the held record while stalled
    always @(negedge clk) begin
        if (acc_rst) rst_hi_cnt++;
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got idx=%0d, expected no record", res_idx);
            end else if (res_ready) begin
                rec_t e;
                e = exp_q.pop_front();
                chk("rec_idx", 32'(res_idx), 32'(e.idx));
                chk("rec_digit", 32'(res_digit), 32'(e.dig));
                chk("rec_cycles", 32'(res_cycles), 32'(e.cyc));
                chk("rec_timeout", 32'(res_timeout), 32'(e.tmo));
                rec_cnt++;
            end else begin
                chk("held_idx", 32'(res_idx), 32'(exp_q[0].idx));
                chk("held_cycles", 32'(res_cycles), 32'(exp_q[0].cyc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic push_req(input logic [3:0] idx);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_idx   = idx;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait idx=%0d: req_ready got 0 expected 1 within 200 cycles", idx);
        end else begin
            exp_q.push_back(exp_of(idx));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && sched_state == 3'd0 && q_count == 3'd0 && !res_valid) && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_wait: %0d records outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int snap_rst;
        int bad_sel;
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_idx = 4'd0;
        res_ready = 1'b1;
        step(3);
        rst = 1'b0;

        // Reset values
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_acc_start", 32'(acc_start), 32'd0);
        chk("rst_acc_rst", 32'(acc_rst), 32'd0);
        chk("rst_img_sel", 32'(acc_img_sel), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_idx", 32'(res_idx), 32'd0);
        chk("rst_res_digit", 32'(res_digit), 32'd0);
        chk("rst_res_cycles", 32'(res_cycles), 32'd0);
        chk("rst_res_timeout", 32'(res_timeout), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_state", 32'(sched_state), 32'd0);

        // Single job: idx 3 -> digit 7, 9 cycles
        snap = rec_cnt;
        push_req(4'd3);
        chk("launch_qcount", 32'(q_count), 32'd1);
        chk("launch_start_pre", 32'(acc_start), 32'd0);
        step(1);
        chk("launch_start", 32'(acc_start), 32'd1);
        chk("launch_sel", 32'(acc_img_sel), 32'd3);
        chk("launch_qcount_pop", 32'(q_count), 32'd0);
        chk("launch_state", 32'(sched_state), 32'd1);
        bad_sel = 0;
        n = 0;
        while (rec_cnt == snap && n < 100) begin
            if (acc_start && acc_img_sel != 4'd3) bad_sel++;
            step(1);
            n++;
        end
        chk("single_sel_stable", 32'(bad_sel), 32'd0);
        chk("single_sel_hold", 32'(acc_img_sel), 32'd3);
        wait_drain();
        chk("single_one_record", 32'(rec_cnt - snap), 32'd1);

        // Fill: long job running, four more fill the FIFO, fifth waits for a pop
        snap = rec_cnt;
        push_req(4'd13);
        step(3);
        push_req(4'd0);
        push_req(4'd1);
        push_req(4'd2);
        push_req(4'd4);
        chk("fill_ready", 32'(req_ready), 32'd0);
        chk("fill_qcount", 32'(q_count), 32'd4);
        push_req(4'd5);
        wait_drain();
        chk("fill_records", 32'(rec_cnt - snap), 32'd6);

        // Simultaneous push/pop at q_count=1, then wrap over 10 more
        snap = rec_cnt;
        push_req(4'd5);
        push_req(4'd6);
        chk("pushpop_qcount", 32'(q_count), 32'd1);
        chk("pushpop_state", 32'(sched_state), 32'd1);
        for (int i = 0; i < 10; i++) push_req(4'(i));
        wait_drain();
        chk("wrap_records", 32'(rec_cnt - snap), 32'd12);

        // Timeout then a normal job
        snap = rec_cnt;
        snap_rst = rst_hi_cnt;
        push_req(4'd12);
        push_req(4'd4);
        wait_drain();
        chk("tmo_rst_cycles", 32'(rst_hi_cnt - snap_rst), 32'd2);
        chk("tmo_records", 32'(rec_cnt - snap), 32'd2);

        // Backpressure: two jobs complete while the consumer is stalled
        snap = rec_cnt;
        res_ready = 1'b0;
        push_req(4'd1);
        push_req(4'd2);
        step(40);
        chk("bp_state", 32'(sched_state), 32'd4);
        chk("bp_start", 32'(acc_start), 32'd0);
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_idx", 32'(res_idx), 32'd1);
        chk("bp_digit", 32'(res_digit), 32'd1);
        chk("bp_cycles", 32'(res_cycles), 32'd2);
        res_ready = 1'b1;
        wait_drain();
        chk("bp_records", 32'(rec_cnt - snap), 32'd2);

        // Reset mid-RUN with two queued
        push_req(4'd13);
        push_req(4'd0);
        push_req(4'd1);
        chk("mid_qcount", 32'(q_count), 32'd2);
        step(2);
        chk("mid_running", 32'(acc_start), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_start", 32'(acc_start), 32'd0);
        chk("mid_rst_qcount", 32'(q_count), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_state", 32'(sched_state), 32'd0);
        exp_q.delete();
        snap = rec_cnt;
        step(40);
        chk("mid_no_record", 32'(rec_cnt - snap), 32'd0);
        chk("mid_idle_start", 32'(acc_start), 32'd0);

        // Normal operation after reset
        snap = rec_cnt;
        push_req(4'd7);
        wait_drain();
        chk("post_rst_record", 32'(rec_cnt - snap), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
